// File: rtl/eu_writeback_way0.sv
// eu_writeback_way0
//   Way0 writeback buffer. It sits between the execute stage and the commit/retire
//   side. Completed EU results are accepted with a valid/ready handshake and held
//   in a DEPTH-entry FIFO. The head entry drives the register-file write port and
//   the commit interface. A 64-bit counter tracks how many instructions retired.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   valid_i/ready_o   EU result handshake (ready_o depends only on occupancy)
//   rdAddr_i, rdWriteEnable_i, result_i, instAddr_i, way0_pID_i  EU result fields
//   flush_i           drops every buffered result and the one offered this cycle
//   valid_o/ready_i   commit handshake for the head entry
//   rdAddr_o, result_o, instAddr_o, way0_pID_o                   head entry fields
//   regWe_o           register-file write strobe for the popped head
//   retireCount_o     count of retired instructions (wraps modulo 2^64)
module eu_writeback_way0 #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [4:0]        rdAddr_i,
  input  logic              rdWriteEnable_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [PC_W-1:0]   instAddr_i,
  input  logic [1:0]        way0_pID_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [4:0]        rdAddr_o,
  output logic [DATA_W-1:0] result_o,
  output logic [PC_W-1:0]   instAddr_o,
  output logic [1:0]        way0_pID_o,
  output logic              regWe_o,
  output logic [63:0]       retireCount_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [63:0]       retire_cnt;

  logic [4:0]        rd_mem  [DEPTH];
  logic              we_mem  [DEPTH];
  logic [DATA_W-1:0] res_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem  [DEPTH];
  logic [1:0]        pid_mem [DEPTH];

  logic push;
  logic pop;

  // Back-pressure looks only at occupancy, so the EU never waits on the commit side
  // through a combinational path. Holding ready low during reset keeps the EU from
  // seeing an accept while the buffer is being cleared.
  assign ready_o = (count != FULL) & ~reset;
  assign valid_o = (count != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  assign rdAddr_o      = rd_mem[rd_ptr];
  assign result_o      = res_mem[rd_ptr];
  assign instAddr_o    = pc_mem[rd_ptr];
  assign way0_pID_o    = pid_mem[rd_ptr];
  assign retireCount_o = retire_cnt;

  // x0 is hard-wired zero: the entry still retires but never writes the file.
  assign regWe_o = pop & we_mem[rd_ptr] & (rd_mem[rd_ptr] != 5'd0) & ~flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]  <= '0;
        we_mem[i]  <= 1'b0;
        res_mem[i] <= '0;
        pc_mem[i]  <= '0;
        pid_mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Stored fields are left as-is; with count at zero they are never observed
      // as valid.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rd_mem[wr_ptr]  <= rdAddr_i;
        we_mem[wr_ptr]  <= rdWriteEnable_i;
        res_mem[wr_ptr] <= result_i;
        pc_mem[wr_ptr]  <= instAddr_i;
        pid_mem[wr_ptr] <= way0_pID_i;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        retire_cnt <= retire_cnt + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_eu_writeback_way0.sv
module tb_eu_writeback_way0;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 64;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_i;
  logic              ready_o;
  logic [4:0]        rdAddr_i;
  logic              rdWriteEnable_i;
  logic [DATA_W-1:0] result_i;
  logic [PC_W-1:0]   instAddr_i;
  logic [1:0]        way0_pID_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [4:0]        rdAddr_o;
  logic [DATA_W-1:0] result_o;
  logic [PC_W-1:0]   instAddr_o;
  logic [1:0]        way0_pID_o;
  logic              regWe_o;
  logic [63:0]       retireCount_o;

  eu_writeback_way0 #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .ready_o(ready_o),
    .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i),
    .result_i(result_i), .instAddr_i(instAddr_i), .way0_pID_i(way0_pID_i),
    .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .rdAddr_o(rdAddr_o), .result_o(result_o), .instAddr_o(instAddr_o),
    .way0_pID_o(way0_pID_o), .regWe_o(regWe_o), .retireCount_o(retireCount_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        rd;
    logic              we;
    logic [DATA_W-1:0] res;
    logic [PC_W-1:0]   pc;
    logic [1:0]        pid;
  } ent_t;

  // Reference model: the expected buffer contents in commit order plus the
  // expected number of retirements.
  ent_t        sb[$];
  logic [63:0] exp_cnt = 64'd0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  event        drv_ev;

  ent_t pend;
  bit   pend_v = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One EU/commit cycle. Percentages select how often a new result is offered,
  // the commit side is ready, a flush fires and a new result targets x0.
  task automatic step(input int p_valid, input int p_ready, input int p_flush, input int p_x0);
    int sz;
    @(negedge clk);
    if (!pend_v && $urandom_range(99) < p_valid) begin
      pend.rd  = ($urandom_range(99) < p_x0) ? 5'd0 : 5'($urandom_range(31));
      pend.we  = ($urandom_range(3) != 0);
      pend.res = {$urandom, $urandom};
      pend.pc  = $urandom;
      pend.pid = 2'($urandom_range(3));
      pend_v   = 1'b1;
    end
    valid_i         = pend_v;
    rdAddr_i        = pend.rd;
    rdWriteEnable_i = pend.we;
    result_i        = pend.res;
    instAddr_i      = pend.pc;
    way0_pID_i      = pend.pid;
    ready_i         = ($urandom_range(99) < p_ready);
    flush_i         = ($urandom_range(99) < p_flush);
    sz = sb.size();
    -> drv_ev;
    @(posedge clk);
    if (flush_i) begin
      pend_v = 1'b0;
    end else if (valid_i && sz < DEPTH) begin
      sb.push_back(pend);
      pend_v = 1'b0;
    end
  endtask

  task automatic async_reset_mid_cycle();
    @(negedge clk);
    #3;
    mon_en  = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_regWe_o", 64'(regWe_o), 64'd0);
    chk("rst_retireCount_o", retireCount_o, 64'd0);
    sb.delete();
    exp_cnt = 64'd0;
    pend_v  = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready_o", 64'(ready_o), 64'd1);
    mon_en = 1'b1;
  endtask

  // Monitor: samples between edges, after the driver has settled the inputs.
  initial begin
    ent_t h;
    bit   exp_vld;
    bit   do_pop;
    forever begin
      @(drv_ev);
      #1;
      if (mon_en) begin
        exp_vld = (sb.size() != 0);
        chk("ready_o", 64'(ready_o), 64'(sb.size() < DEPTH));
        chk("valid_o", 64'(valid_o), 64'(exp_vld));
        do_pop = exp_vld && ready_i;
        if (exp_vld) begin
          h = sb[0];
          chk("rdAddr_o", 64'(rdAddr_o), 64'(h.rd));
          chk("result_o", result_o, h.res);
          chk("instAddr_o", 64'(instAddr_o), 64'(h.pc));
          chk("way0_pID_o", 64'(way0_pID_o), 64'(h.pid));
          chk("regWe_o", 64'(regWe_o),
              64'(do_pop && h.we && h.rd != 5'd0 && !flush_i));
        end else begin
          chk("regWe_o_idle", 64'(regWe_o), 64'd0);
        end
        chk("retireCount_o", retireCount_o, exp_cnt);
        if (flush_i) begin
          sb.delete();
        end else if (do_pop) begin
          void'(sb.pop_front());
          exp_cnt = exp_cnt + 64'd1;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    rdAddr_i = '0; rdWriteEnable_i = 1'b0; result_i = '0; instAddr_i = '0; way0_pID_i = '0;
    pend = '{rd: 5'd0, we: 1'b0, res: '0, pc: '0, pid: 2'd0};
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready_o", 64'(ready_o), 64'd0);
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_regWe_o", 64'(regWe_o), 64'd0);
    chk("reset_retireCount_o", retireCount_o, 64'd0);
    chk("reset_result_o", result_o, 64'd0);
    chk("reset_rdAddr_o", 64'(rdAddr_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_ready_o", 64'(ready_o), 64'd1);
    mon_en = 1'b1;

    // Single result to rd=5, drained with the commit side always ready.
    pend = '{rd: 5'd5, we: 1'b1, res: 64'hDEAD_BEEF, pc: 32'h100, pid: 2'd1};
    pend_v = 1'b1;
    repeat (4) step(0, 100, 0, 0);

    // Back-pressure: fill past DEPTH with commit stalled, then release.
    repeat (6) step(100, 0, 0, 0);
    repeat (6) step(100, 100, 0, 0);
    repeat (4) step(0, 100, 0, 0);

    // Streaming.
    repeat (10) step(100, 100, 0, 0);
    repeat (3) step(0, 100, 0, 0);

    // Writes aimed at x0.
    repeat (12) step(100, 100, 0, 100);
    repeat (3) step(0, 100, 0, 0);

    // Flush with a full buffer while both sides are active.
    repeat (4) step(100, 0, 0, 0);
    step(100, 100, 100, 0);
    repeat (3) step(100, 100, 0, 0);

    // Asynchronous reset in the middle of a burst.
    repeat (5) step(100, 50, 0, 0);
    async_reset_mid_cycle();
    repeat (4) step(100, 100, 0, 0);

    // Randomized traffic with occasional flushes and resets.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 300; i++) step(70, 60, 3, 15);
      async_reset_mid_cycle();
    end
    repeat (4) step(0, 100, 0, 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
